// File: rtl/usb_rw_ctrl.sv
// Host-side read/write transaction controller: runs an address phase then a data
// phase through the protocol FSM, with bounded per-phase retries.
module usb_rw_ctrl #(
  parameter int unsigned DATA_BYTES  = 8,
  parameter int unsigned PAGE_W      = 16,
  parameter logic [6:0]  DEV_ADDR    = 7'b1010000,
  parameter logic [3:0]  ENDP_ADDR   = 4'b0010,
  parameter logic [3:0]  ENDP_DATA   = 4'b0001,
  parameter int unsigned MAX_RETRIES = 2,
  localparam int unsigned DW         = 8 * DATA_BYTES
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      tsk,
  input  logic            task_start,
  input  logic [PAGE_W-1:0] mempage,
  input  logic [DW-1:0]   data_in,
  output logic            task_busy,
  output logic            task_done,
  output logic            task_success,
  output logic [DW-1:0]   data_to_tb,
  output logic [3:0]      retry_cnt,
  output logic            ptcl_start,
  input  logic            ptcl_ready,
  input  logic            ptcl_done,
  input  logic            ptcl_success,
  input  logic [DW-1:0]   ptcl_data,
  output logic [18:0]     token_pkt_out,
  output logic [8+DW-1:0] data_pkt_out,
  output logic            data_avail
);

  localparam logic [7:0] PID_OUT  = 8'b10000111;
  localparam logic [7:0] PID_IN   = 8'b10010110;
  localparam logic [7:0] PID_DATA = 8'b11000011;
  localparam logic [1:0] OP_READ  = 2'b01;
  localparam logic [1:0] OP_WRITE = 2'b10;
  localparam logic [3:0] RETRY_MAX = 4'(MAX_RETRIES);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    A_REQ  = 3'd1,
    A_WAIT = 3'd2,
    D_REQ  = 3'd3,
    D_WAIT = 3'd4,
    FIN    = 3'd5
  } state_t;

  state_t              state, state_nxt;
  logic [1:0]          op_q;
  logic [PAGE_W-1:0]   page_q;
  logic [DW-1:0]       wdata_q;
  logic                result_q, result_nxt;
  logic [3:0]          retry_nxt;
  logic                accept;
  logic                load_rd;

  function automatic logic [DW-1:0] bit_rev(input logic [DW-1:0] v);
    logic [DW-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < DW; i++) begin
      r[DW-1-i] = v[i];
    end
    return r;
  endfunction

  // State, retry counter, result flag, latched operands and read-back register
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      op_q       <= '0;
      page_q     <= '0;
      wdata_q    <= '0;
      result_q   <= 1'b0;
      retry_cnt  <= '0;
      data_to_tb <= '0;
    end else begin
      state     <= state_nxt;
      result_q  <= result_nxt;
      retry_cnt <= retry_nxt;
      if (accept) begin
        op_q    <= tsk;
        page_q  <= mempage;
        wdata_q <= data_in;
      end
      if (load_rd) begin
        data_to_tb <= ptcl_data;
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    result_nxt = result_q;
    retry_nxt  = retry_cnt;
    accept     = 1'b0;
    load_rd    = 1'b0;
    case (state)
      IDLE: begin
        if (task_start) begin
          accept = 1'b1;
          retry_nxt  = '0;
          result_nxt = 1'b0;
          if (tsk == OP_READ || tsk == OP_WRITE) begin
            state_nxt = A_REQ;
          end else if (tsk == 2'b11) begin
            state_nxt = FIN;
          end
        end
      end
      A_REQ: begin
        if (ptcl_ready) state_nxt = A_WAIT;
      end
      A_WAIT: begin
        if (ptcl_done) begin
          if (ptcl_success) begin
            state_nxt = D_REQ;
            retry_nxt = '0;
          end else if (retry_cnt < RETRY_MAX) begin
            state_nxt = A_REQ;
            retry_nxt = retry_cnt + 4'd1;
          end else begin
            state_nxt  = FIN;
            result_nxt = 1'b0;
          end
        end
      end
      D_REQ: begin
        if (ptcl_ready) state_nxt = D_WAIT;
      end
      D_WAIT: begin
        if (ptcl_done) begin
          if (ptcl_success) begin
            state_nxt  = FIN;
            result_nxt = 1'b1;
            load_rd    = (op_q == OP_READ);
          end else if (retry_cnt < RETRY_MAX) begin
            state_nxt = D_REQ;
            retry_nxt = retry_cnt + 4'd1;
          end else begin
            state_nxt  = FIN;
            result_nxt = 1'b0;
          end
        end
      end
      FIN: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_comb begin
    task_busy     = (state != IDLE);
    task_done     = (state == FIN);
    task_success  = (state == FIN) && result_q;
    ptcl_start    = (state == A_REQ) || (state == D_REQ);
    token_pkt_out = '0;
    data_pkt_out  = '0;
    data_avail    = 1'b0;
    case (state)
      A_REQ, A_WAIT: begin
        token_pkt_out = {PID_OUT, DEV_ADDR, ENDP_ADDR};
        data_pkt_out  = {PID_DATA, bit_rev(DW'(page_q))};
        data_avail    = 1'b1;
      end
      D_REQ, D_WAIT: begin
        if (op_q == OP_WRITE) begin
          token_pkt_out = {PID_OUT, DEV_ADDR, ENDP_DATA};
          data_pkt_out  = {PID_DATA, bit_rev(wdata_q)};
          data_avail    = 1'b1;
        end else begin
          token_pkt_out = {PID_IN, DEV_ADDR, ENDP_DATA};
        end
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_usb_rw_ctrl.sv
// Directed bench for usb_rw_ctrl: inputs change and outputs are checked on the
// falling edge, with hand-computed expected packets and results.
module tb_usb_rw_ctrl;

  logic        clk;
  logic        rst;
  logic [1:0]  tsk;
  logic        task_start;
  logic [15:0] mempage;
  logic [63:0] data_in;
  logic        task_busy;
  logic        task_done;
  logic        task_success;
  logic [63:0] data_to_tb;
  logic [3:0]  retry_cnt;
  logic        ptcl_start;
  logic        ptcl_ready;
  logic        ptcl_done;
  logic        ptcl_success;
  logic [63:0] ptcl_data;
  logic [18:0] token_pkt_out;
  logic [71:0] data_pkt_out;
  logic        data_avail;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  usb_rw_ctrl #(
    .DATA_BYTES  (8),
    .PAGE_W      (16),
    .DEV_ADDR    (7'b1010000),
    .ENDP_ADDR   (4'b0010),
    .ENDP_DATA   (4'b0001),
    .MAX_RETRIES (2)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .tsk           (tsk),
    .task_start    (task_start),
    .mempage       (mempage),
    .data_in       (data_in),
    .task_busy     (task_busy),
    .task_done     (task_done),
    .task_success  (task_success),
    .data_to_tb    (data_to_tb),
    .retry_cnt     (retry_cnt),
    .ptcl_start    (ptcl_start),
    .ptcl_ready    (ptcl_ready),
    .ptcl_done     (ptcl_done),
    .ptcl_success  (ptcl_success),
    .ptcl_data     (ptcl_data),
    .token_pkt_out (token_pkt_out),
    .data_pkt_out  (data_pkt_out),
    .data_avail    (data_avail)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check_idle(input string tag);
    check({tag, " busy"},  128'(task_busy), 128'(1'b0));
    check({tag, " done"},  128'(task_done), 128'(1'b0));
    check({tag, " succ"},  128'(task_success), 128'(1'b0));
    check({tag, " start"}, 128'(ptcl_start), 128'(1'b0));
    check({tag, " token"}, 128'(token_pkt_out), 128'(0));
    check({tag, " pkt"},   128'(data_pkt_out), 128'(0));
    check({tag, " avail"}, 128'(data_avail), 128'(1'b0));
  endtask

  // Issue a task, then scramble the inputs to prove the operands were latched
  task automatic start_task(input logic [1:0] t, input logic [15:0] pg, input logic [63:0] din);
    tsk = t; mempage = pg; data_in = din; task_start = 1'b1;
    tick();
    task_start = 1'b0; tsk = 2'b00; mempage = 16'hA5A5; data_in = 64'h5A5A_5A5A_5A5A_5A5A;
  endtask

  // Called with the DUT in a REQ state: checks it, hands over ready then done
  task automatic do_phase(input string tag, input logic [18:0] tok, input logic [71:0] pkt,
                          input logic av, input logic [3:0] rc, input logic ok,
                          input logic [63:0] rdata);
    check({tag, " req start"}, 128'(ptcl_start), 128'(1'b1));
    check({tag, " req token"}, 128'(token_pkt_out), 128'(tok));
    check({tag, " req pkt"},   128'(data_pkt_out), 128'(pkt));
    check({tag, " req avail"}, 128'(data_avail), 128'(av));
    check({tag, " retry"},     128'(retry_cnt), 128'(rc));
    check({tag, " busy"},      128'(task_busy), 128'(1'b1));
    ptcl_ready = 1'b1;
    tick();
    ptcl_ready = 1'b0;
    check({tag, " wait start"}, 128'(ptcl_start), 128'(1'b0));
    check({tag, " wait token"}, 128'(token_pkt_out), 128'(tok));
    ptcl_done = 1'b1; ptcl_success = ok; ptcl_data = rdata;
    tick();
    ptcl_done = 1'b0; ptcl_success = 1'b0; ptcl_data = 64'hFFFF_0000_FFFF_0000;
  endtask

  task automatic check_fin(input string tag, input logic ok, input logic [63:0] rd);
    check({tag, " done"},  128'(task_done), 128'(1'b1));
    check({tag, " succ"},  128'(task_success), 128'(ok));
    check({tag, " rdata"}, 128'(data_to_tb), 128'(rd));
    tick();
    check({tag, " done drop"}, 128'(task_done), 128'(1'b0));
    check({tag, " idle"},      128'(task_busy), 128'(1'b0));
  endtask

  initial begin
    rst = 1'b1; tsk = 2'b00; task_start = 1'b0; mempage = '0; data_in = '0;
    ptcl_ready = 1'b0; ptcl_done = 1'b0; ptcl_success = 1'b0; ptcl_data = '0;
    tick(); tick();
    check_idle("reset");
    check("reset rdata", 128'(data_to_tb), 128'(0));
    check("reset retry", 128'(retry_cnt), 128'(0));
    rst = 1'b0;
    tick();

    // 1. read, no errors
    start_task(2'b01, 16'h0001, 64'h0);
    do_phase("t1 A", 19'h43D02, 72'hC3_8000_0000_0000_0000, 1'b1, 4'd0, 1'b1, 64'h0);
    do_phase("t1 D", 19'h4B501, 72'h0, 1'b0, 4'd0, 1'b1, 64'hDEAD_BEEF_0000_0001);
    check_fin("t1", 1'b1, 64'hDEAD_BEEF_0000_0001);

    // 2. write, no errors; returned data must not load data_to_tb
    start_task(2'b10, 16'h8000, 64'h1);
    do_phase("t2 A", 19'h43D02, 72'hC3_0001_0000_0000_0000, 1'b1, 4'd0, 1'b1, 64'h0);
    do_phase("t2 D", 19'h43D01, 72'hC3_8000_0000_0000_0000, 1'b1, 4'd0, 1'b1, 64'h1111);
    check_fin("t2", 1'b1, 64'hDEAD_BEEF_0000_0001);

    // 3. address phase fails twice, then succeeds
    start_task(2'b01, 16'h0003, 64'h0);
    do_phase("t3 A0", 19'h43D02, 72'hC3_C000_0000_0000_0000, 1'b1, 4'd0, 1'b0, 64'h0);
    do_phase("t3 A1", 19'h43D02, 72'hC3_C000_0000_0000_0000, 1'b1, 4'd1, 1'b0, 64'h0);
    do_phase("t3 A2", 19'h43D02, 72'hC3_C000_0000_0000_0000, 1'b1, 4'd2, 1'b1, 64'h0);
    do_phase("t3 D",  19'h4B501, 72'h0, 1'b0, 4'd0, 1'b1, 64'h0123_4567_89AB_CDEF);
    check_fin("t3", 1'b1, 64'h0123_4567_89AB_CDEF);

    // 4. data phase fails three times: retries exhausted
    start_task(2'b01, 16'h0000, 64'h0);
    do_phase("t4 A",  19'h43D02, 72'hC3_0000_0000_0000_0000, 1'b1, 4'd0, 1'b1, 64'h0);
    do_phase("t4 D0", 19'h4B501, 72'h0, 1'b0, 4'd0, 1'b0, 64'h1);
    do_phase("t4 D1", 19'h4B501, 72'h0, 1'b0, 4'd1, 1'b0, 64'h2);
    do_phase("t4 D2", 19'h4B501, 72'h0, 1'b0, 4'd2, 1'b0, 64'h3);
    check_fin("t4", 1'b0, 64'h0123_4567_89AB_CDEF);

    // 5. ready stall, spurious done in A_REQ, task_start while busy
    start_task(2'b10, 16'h0001, 64'h2);
    ptcl_done = 1'b1; ptcl_success = 1'b1;
    tsk = 2'b01; mempage = 16'hFFFF; task_start = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("t5 stall start", 128'(ptcl_start), 128'(1'b1));
      check("t5 stall token", 128'(token_pkt_out), 128'(19'h43D02));
      check("t5 stall pkt",   128'(data_pkt_out), 128'(72'hC3_8000_0000_0000_0000));
      tick();
      ptcl_done = 1'b0; ptcl_success = 1'b0; task_start = 1'b0; tsk = 2'b00;
    end
    do_phase("t5 A", 19'h43D02, 72'hC3_8000_0000_0000_0000, 1'b1, 4'd0, 1'b1, 64'h0);
    do_phase("t5 D", 19'h43D01, 72'hC3_4000_0000_0000_0000, 1'b1, 4'd0, 1'b1, 64'h0);
    check_fin("t5", 1'b1, 64'h0123_4567_89AB_CDEF);

    // 6a. idle task ignored, reserved task fails one cycle after accept
    start_task(2'b00, 16'h0001, 64'h0);
    check_idle("t6 tsk00");
    start_task(2'b11, 16'h0001, 64'h0);
    check("t6 tsk11 start", 128'(ptcl_start), 128'(1'b0));
    check("t6 tsk11 busy",  128'(task_busy), 128'(1'b1));
    check_fin("t6 tsk11", 1'b0, 64'h0123_4567_89AB_CDEF);

    // 6b. reset while in D_WAIT with one retry used
    start_task(2'b01, 16'h0001, 64'h0);
    do_phase("t6 A",  19'h43D02, 72'hC3_8000_0000_0000_0000, 1'b1, 4'd0, 1'b1, 64'h0);
    do_phase("t6 D0", 19'h4B501, 72'h0, 1'b0, 4'd0, 1'b0, 64'h0);
    check("t6 retry before rst", 128'(retry_cnt), 128'(4'd1));
    ptcl_ready = 1'b1;
    tick();
    ptcl_ready = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_idle("t6 rst");
    check("t6 rst retry", 128'(retry_cnt), 128'(0));
    check("t6 rst rdata", 128'(data_to_tb), 128'(0));
    tick();
    check("t6 no done after rst", 128'(task_done), 128'(1'b0));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
